read_pointer_handler_sync: RTL and testbench

//  Read-side pointer logic for the async FIFO. It lives in the rx clock domain, opposite the write-side handler.

---
 rtl/read_pointer_handler_sync.sv | 76 +++++++
 tb/tb_read_pointer_handler_sync.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/read_pointer_handler_sync.sv
// Read-side pointer handler for an async FIFO (rx clock domain).
// Synchronises the remote gray write pointer and derives empty, occupancy and the exported gray read pointer.
module read_pointer_handler_sync #(
    parameter int ADDR_WIDTH    = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk_rx,
    input  logic                  rst_rx,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   graycoded_write_pointer,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH-1:0] read_pointer,
    output logic [ADDR_WIDTH:0]   graycoded_read_pointer,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // XOR-prefix decode, MSB first
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][PW-1:0] wsync_q;
    logic [PW-1:0]                  rcnt_q, rcnt_d;
    logic [PW-1:0]                  rgray_q;
    logic                           underflow_q, underflow_d;
    logic [PW-1:0]                  synced_wptr;
    logic [PW-1:0]                  wbin;
    logic                           pop_ok;

    assign synced_wptr = wsync_q[SYNC_STAGES-1];
    assign wbin        = gray2bin(synced_wptr);

    assign empty        = (bin2gray(rcnt_q) == synced_wptr);
    assign rd_count     = wbin - rcnt_q;
    assign almost_empty = (rd_count <= PW'(AEMPTY_THRESH));
    assign read_pointer = rcnt_q[ADDR_WIDTH-1:0];

    assign graycoded_read_pointer = rgray_q;
    assign underflow              = underflow_q;

    // Empty check uses the pre-edge synchronised pointer, so a pop racing a
    // write-pointer update is judged against the old view.
    assign pop_ok      = pop && !empty;
    assign rcnt_d      = pop_ok ? rcnt_q + PW'(1) : rcnt_q;
    assign underflow_d = underflow_q | (pop && empty);

    always_ff @(posedge clk_rx) begin
        if (rst_rx) begin
            wsync_q     <= '0;
            rcnt_q      <= '0;
            rgray_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            // Pure flop chain: nothing may sit between stages.
            wsync_q     <= {wsync_q[SYNC_STAGES-2:0], graycoded_write_pointer};
            rcnt_q      <= rcnt_d;
            rgray_q     <= bin2gray(rcnt_q);
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_read_pointer_handler_sync.sv
// Scoreboard bench for read_pointer_handler_sync: random and directed stimulus
// against a count-based reference model, checked by a decoupled negedge monitor.
module tb_read_pointer_handler_sync;

    localparam int AW = 3;
    localparam int SS = 2;
    localparam int PW = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int PMASK = (1 << PW) - 1;

    logic          clk_rx = 1'b0;
    logic          rst_rx;
    logic          pop;
    logic [PW-1:0] graycoded_write_pointer;
    logic          empty;
    logic          almost_empty;
    logic [AW-1:0] read_pointer;
    logic [PW-1:0] graycoded_read_pointer;
    logic [PW-1:0] rd_count;
    logic          underflow;

    read_pointer_handler_sync #(
        .ADDR_WIDTH   (AW),
        .SYNC_STAGES  (SS),
        .AEMPTY_THRESH(1)
    ) dut (
        .clk_rx                 (clk_rx),
        .rst_rx                 (rst_rx),
        .pop                    (pop),
        .graycoded_write_pointer(graycoded_write_pointer),
        .empty                  (empty),
        .almost_empty           (almost_empty),
        .read_pointer           (read_pointer),
        .graycoded_read_pointer (graycoded_read_pointer),
        .rd_count               (rd_count),
        .underflow              (underflow)
    );

    always #5 clk_rx = ~clk_rx;

    typedef struct {
        logic          rst;
        logic          e;
        logic          ae;
        logic [AW-1:0] rp;
        logic [PW-1:0] gp;
        logic [PW-1:0] cnt;
        logic          uf;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: writes/reads as plain counts; the synchroniser is a
    // delay line of write counts, SS edges deep.
    int   wcount = 0;
    int   rc     = 0;
    logic uf_m   = 1'b0;
    int   wdelay[$];
    int   gp_m   = 0;

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) & PMASK;
    endfunction

    function automatic int visible_w();
        return wdelay[0] & PMASK;
    endfunction

    task automatic step(input logic r, input logic p);
        int   occ_pre;
        exp_t e;
        rst_rx = r;
        pop    = p;
        graycoded_write_pointer = PW'(gray_of(wcount & PMASK));
        @(posedge clk_rx);
        if (r) begin
            rc   = 0;
            uf_m = 1'b0;
            gp_m = 0;
            wdelay.delete();
            for (int i = 0; i < SS; i++) wdelay.push_back(0);
        end else begin
            occ_pre = (visible_w() - (rc & PMASK)) & PMASK;
            gp_m    = gray_of(rc & PMASK);
            if (p) begin
                if (occ_pre != 0) rc++;
                else uf_m = 1'b1;
            end
            wdelay.push_back(wcount & PMASK);
            void'(wdelay.pop_front());
        end
        e.rst = r;
        e.cnt = PW'((visible_w() - (rc & PMASK)) & PMASK);
        e.e   = (e.cnt == 0);
        e.ae  = (e.cnt <= 1);
        e.rp  = AW'(rc % DEPTH);
        e.gp  = PW'(gp_m);
        e.uf  = uf_m;
        expq.push_back(e);
        #1;
    endtask

    // Writer side only ever stays within true capacity.
    task automatic try_write();
        if (wcount - rc < DEPTH) wcount++;
    endtask

    task automatic do_reset(input int n);
        wcount = 0;
        repeat (n) step(1'b1, 1'b0);
    endtask

    // Monitor
    logic [PW-1:0] prev_gp;
    logic          prev_ok = 1'b0;
    always @(negedge clk_rx) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if ({empty, almost_empty, read_pointer, graycoded_read_pointer, rd_count, underflow} !==
                {e.e, e.ae, e.rp, e.gp, e.cnt, e.uf}) begin
                errors++;
                $display("FAIL outputs t=%0t got e=%b ae=%b rp=%0d gp=%b cnt=%0d uf=%b exp e=%b ae=%b rp=%0d gp=%b cnt=%0d uf=%b",
                         $time, empty, almost_empty, read_pointer, graycoded_read_pointer, rd_count, underflow,
                         e.e, e.ae, e.rp, e.gp, e.cnt, e.uf);
            end
            if (prev_ok && !e.rst) begin
                checks++;
                if ($countones(prev_gp ^ graycoded_read_pointer) > 1) begin
                    errors++;
                    $display("FAIL gray_hamming t=%0t got %b after %b, need <=1 bit change",
                             $time, graycoded_read_pointer, prev_gp);
                end
            end
            prev_gp = graycoded_read_pointer;
            prev_ok = 1'b1;
        end
    end

    initial begin
        rst_rx = 1'b1;
        pop    = 1'b0;
        graycoded_write_pointer = '0;

        // T1 reset
        do_reset(2);
        repeat (2) step(1'b0, 1'b0);

        // T2 latency of one write, then a single pop
        wcount = 1;
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // T3 full occupancy, then drain to one
        do_reset(1);
        wcount = DEPTH;
        repeat (3) step(1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // T4 underflow, sticky across later pops
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        wcount = wcount + 2;
        repeat (3) step(1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1);

        // T5 write/pop pairs with random gaps, wrapping the counter
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            try_write();
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
        end
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 55) try_write();
            step(1'b0, logic'($urandom_range(0, 99) < 50));
        end

        // T6 reset mid-run with pop asserted
        do_reset(1);
        wcount = 5;
        repeat (3) step(1'b0, 1'b0);
        wcount = 0;
        step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        rst_rx = 1'b0;
        pop    = 1'b0;
        repeat (3) @(negedge clk_rx);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending, need 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
